// File: rtl/count_seq_checker_if.sv
// Bus between a counter-sequence checker and whatever drives and observes it.
// The master drives sample/q_in/clr; the slave (the checker) returns the status.
interface count_seq_checker_if #(
    parameter int WRAP_W = 8
);
    logic              sample;
    logic [3:0]        q_in;
    logic              clr;
    logic              locked;
    logic              err;
    logic              err_pulse;
    logic [3:0]        exp_q;
    logic [3:0]        bad_q;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output sample, q_in, clr,
        input  locked, err, err_pulse, exp_q, bad_q, wrap_cnt
    );

    modport slave (
        input  sample, q_in, clr,
        output locked, err, err_pulse, exp_q, bad_q, wrap_cnt
    );
endinterface

// File: rtl/count_seq_checker.sv
// Checks that a sampled 4-bit counter advances by exactly +1 (mod 16) per sample.
// Optional macro CHK_AUTO_RESYNC_EN lets FAULT return to TRACK after RESYNC_LEN good samples.
module count_seq_checker #(
    parameter int WRAP_W     = 8,
    parameter int RESYNC_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    count_seq_checker_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    if (RESYNC_LEN < 1 || RESYNC_LEN > 15) begin : g_bad_resync_len
        $error("RESYNC_LEN must be in 1..15");
    end

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + WRAP_W'(1);
        end
    endfunction

    state_t            r_state;
    logic              r_locked;
    logic              r_err;
    logic              r_err_pulse;
    logic [3:0]        r_exp_q;
    logic [3:0]        r_bad_q;
    logic [WRAP_W-1:0] r_wrap_cnt;

    state_t            w_state_nxt;
    logic              w_err_nxt;
    logic              w_pulse_nxt;
    logic [3:0]        w_exp_nxt;
    logic [3:0]        w_bad_nxt;
    logic [WRAP_W-1:0] w_wrap_nxt;
    logic [3:0]        w_q_inc;
    logic              w_match;
    logic              w_zero;

`ifdef CHK_AUTO_RESYNC_EN
    localparam logic [3:0] RESYNC_CNT = 4'(RESYNC_LEN);
    logic [3:0]        r_good_run;
    logic [3:0]        w_good_nxt;
`endif

    assign w_q_inc = bus.q_in + 4'd1;
    assign w_match = (bus.q_in == r_exp_q);
    assign w_zero  = (bus.q_in == 4'd0);

    // Next-state and next-register-value decode; clr outranks sample.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_pulse_nxt = 1'b0;
        w_exp_nxt   = r_exp_q;
        w_bad_nxt   = r_bad_q;
        w_wrap_nxt  = r_wrap_cnt;
`ifdef CHK_AUTO_RESYNC_EN
        w_good_nxt  = r_good_run;
`endif
        if (bus.clr) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b0;
            w_exp_nxt   = 4'd0;
            w_bad_nxt   = 4'd0;
            w_wrap_nxt  = '0;
`ifdef CHK_AUTO_RESYNC_EN
            w_good_nxt  = 4'd0;
`endif
        end else if (bus.sample) begin
            // Every accepted sample re-seeds the expectation from the actual value.
            w_exp_nxt = w_q_inc;
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_match) begin
                        if (w_zero) begin
                            w_wrap_nxt = sat_inc(r_wrap_cnt);
                        end else begin
                            w_wrap_nxt = r_wrap_cnt;
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_pulse_nxt = 1'b1;
                        w_bad_nxt   = bus.q_in;
                        w_state_nxt = ST_FAULT;
`ifdef CHK_AUTO_RESYNC_EN
                        w_good_nxt  = 4'd0;
`endif
                    end
                end
                ST_FAULT: begin
                    if (w_match) begin
                        if (w_zero) begin
                            w_wrap_nxt = sat_inc(r_wrap_cnt);
                        end else begin
                            w_wrap_nxt = r_wrap_cnt;
                        end
`ifdef CHK_AUTO_RESYNC_EN
                        if ((r_good_run + 4'd1) == RESYNC_CNT) begin
                            w_state_nxt = ST_TRACK;
                            w_good_nxt  = 4'd0;
                        end else begin
                            w_good_nxt  = r_good_run + 4'd1;
                        end
`endif
                    end else begin
                        w_bad_nxt  = bus.q_in;
`ifdef CHK_AUTO_RESYNC_EN
                        w_good_nxt = 4'd0;
`endif
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_pulse_nxt = 1'b0;
        end
    end

    // State and output registers; locked is registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_pulse <= 1'b0;
            r_exp_q     <= 4'd0;
            r_bad_q     <= 4'd0;
            r_wrap_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked    <= (w_state_nxt == ST_TRACK);
            r_err       <= w_err_nxt;
            r_err_pulse <= w_pulse_nxt;
            r_exp_q     <= w_exp_nxt;
            r_bad_q     <= w_bad_nxt;
            r_wrap_cnt  <= w_wrap_nxt;
        end
    end

`ifdef CHK_AUTO_RESYNC_EN
    // Run length of consecutive matching samples while in FAULT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_good_run <= 4'd0;
        end else begin
            r_good_run <= w_good_nxt;
        end
    end
`endif

    assign bus.locked    = r_locked;
    assign bus.err       = r_err;
    assign bus.err_pulse = r_err_pulse;
    assign bus.exp_q     = r_exp_q;
    assign bus.bad_q     = r_bad_q;
    assign bus.wrap_cnt  = r_wrap_cnt;

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream monitor for the 4-bit synchronous up counter.
- Samples the counter's q output and checks that each sample is the previous sample +1, modulo 16.
- Reports lock status, a sticky error flag, a single-cycle error pulse, the offending value and a saturating count of 15->0 wraps.
- Used by the lab bench and by the board-level top to flag counter faults on LEDs.

Parameters:
WRAP_W, 8, width of the wrap counter wrap_cnt.
RESYNC_LEN, 4, number of consecutive correct samples needed to leave FAULT; used only when CHK_AUTO_RESYNC_EN is defined; legal range 1..15.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
sample  input  1  qualifies q_in; high = check q_in this cycle.
q_in  input  4  counter value under test (the upstream counter's q).
clr  input  1  synchronous clear of all checker state, active-high.
locked  output  1  high while state = TRACK.
err  output  1  sticky error flag.
err_pulse  output  1  one-cycle pulse on each TRACK->FAULT transition.
exp_q  output  4  next value the checker expects.
bad_q  output  4  q_in value that caused the most recent error.
wrap_cnt  output  WRAP_W  saturating count of correct 15->0 transitions.

Behaviour:
- All outputs are registered. Response appears 1 clk after the sampling edge.
- Reset (rst low): state = IDLE, locked = 0, err = 0, err_pulse = 0, exp_q = 0, bad_q = 0, wrap_cnt = 0, good_run = 0. Applies at any time, including mid-FAULT.
- Priority per edge: clr > sample > hold.
- clr: same effect as reset, but synchronous. A sample in the same cycle is ignored.
- sample = 0: all registers hold; err_pulse = 0.
- err_pulse defaults to 0 every cycle unless set as stated below.
- States: IDLE, TRACK, FAULT (2-bit encoding, internal).
- IDLE: on sample, exp_q <= q_in + 1 (4-bit wrap, 15 -> 0), go to TRACK. No check is made on this first sample.
- TRACK, sample with q_in == exp_q:
  - exp_q <= q_in + 1.
  - If q_in == 0, wrap_cnt <= wrap_cnt + 1, saturating at all-ones.
  - Stay in TRACK.
- TRACK, sample with q_in != exp_q:
  - err <= 1, err_pulse <= 1, bad_q <= q_in.
  - exp_q <= q_in + 1 (re-tracks the actual sequence).
  - good_run <= 0; go to FAULT.
- FAULT, sample:
  - exp_q <= q_in + 1 always.
  - Mismatch: bad_q <= q_in; no err_pulse.
  - Match: wrap_cnt counts as in TRACK. Resync handling is described under Optional Feature.
- err is cleared only by rst or clr. It stays 1 after a return to TRACK.
- locked = 1 exactly when state is TRACK.

Optional Feature:
- Macro: CHK_AUTO_RESYNC_EN.
- Defined:
  - In FAULT, a matching sample increments the 4-bit good_run; a mismatch zeroes it.
  - When a match brings good_run to RESYNC_LEN, go to TRACK and zero good_run. locked rises the cycle after that sample.
- Not defined:
  - FAULT is absorbing until rst or clr.
  - good_run register is not built.

Test Plan:
- Reset then sample 0,1,2,...,15,0,1 on consecutive cycles -> locked = 1 from the cycle after the first sample, err = 0, wrap_cnt = 1, exp_q = 2.
- TRACK at exp_q = 5, sample q_in = 7 -> next cycle err = 1, err_pulse = 1 for exactly one cycle, bad_q = 7, exp_q = 8, locked = 0.
- In FAULT, sample 8,9,10,11:
  - With CHK_AUTO_RESYNC_EN (RESYNC_LEN = 4): locked = 1 after the 11 sample, err stays 1.
  - Without the macro: locked stays 0.
- Force wrap_cnt near saturation (WRAP_W = 2; four full 0..15 cycles) -> wrap_cnt holds 3, no rollover.
- clr and sample high in the same cycle while in FAULT -> IDLE; err = 0, wrap_cnt = 0, exp_q = 0; that sample is not used as the first sample.
- Drop rst mid-sequence between clock edges -> all outputs 0 immediately without a clk edge; the first sample after release re-seeds exp_q.
